fifo_memory: RTL and testbench

FIFO_MEMORY -- requirements
Module: fifo_memory

---
 rtl/dual_port_ram_sync.sv | 40 ++++
 rtl/fifo_memory.sv | 133 +++++++++++++
 tb/tb_fifo_memory.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_sync.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module dual_port_ram_sync #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; holds its value when not enabled, clears on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_memory.sv
// Synchronous FIFO: pointer/occupancy control around a dual-port RAM,
// with threshold flags and sticky overflow/underflow errors.
//
// Request semantics: iPush and iPop are single-cycle requests sampled on the
// rising Clock edge. A pop is accepted when the FIFO is not empty; a push is
// accepted when the FIFO is not full, or when it is full and a pop is accepted
// on the same edge. Rejected requests have no effect on data or pointers and
// set the corresponding sticky error flag. Popped data appears on oDataOut
// with oValid=1 during the cycle after the accepting edge.
module fifo_memory #(
  parameter int DATA_WIDTH      = 6,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  Clock,
  input  logic                  iReset_L,
  input  logic                  iPush,
  input  logic                  iPop,
  input  logic                  iClearErr,
  input  logic [DATA_WIDTH-1:0] iDataIn,
  output logic [DATA_WIDTH-1:0] oDataOut,
  output logic                  oValid,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oAlmostFull,
  output logic                  oAlmostEmpty,
  output logic                  oOverflow,
  output logic                  oUnderflow,
  output logic [ADDR_WIDTH:0]   oCount
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_TH   = ALMOST_FULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_TH   = ALMOST_EMPTY_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop_acc;
  logic                  w_push_acc;
  logic                  w_ovf_evt;
  logic                  w_ufl_evt;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Status decodes from the registered occupancy count.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // Acceptance: pops need data; pushes need room, or a same-edge pop when full.
  assign w_pop_acc  = iPop && !w_empty;
  assign w_push_acc = iPush && (!w_full || w_pop_acc);
  assign w_ovf_evt  = iPush && !w_push_acc;
  assign w_ufl_evt  = iPop && w_empty;

  dual_port_ram_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk     (Clock),
    .i_rst_n   (iReset_L),
    .i_wr_en   (w_push_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (iDataIn),
    .i_rd_en   (w_pop_acc),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Pointer advance; wraps naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge Clock or negedge iReset_L) begin
    if (!iReset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Occupancy counter: moves only when exactly one side is accepted.
  always_ff @(posedge Clock or negedge iReset_L) begin
    if (!iReset_L) begin
      r_count <= '0;
    end else begin
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read-valid strobe lines up with the RAM's registered read data.
  always_ff @(posedge Clock or negedge iReset_L) begin
    if (!iReset_L) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_pop_acc;
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge Clock or negedge iReset_L) begin
    if (!iReset_L) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_evt | (r_overflow  & ~iClearErr);
      r_underflow <= w_ufl_evt | (r_underflow & ~iClearErr);
    end
  end

  assign oDataOut     = w_rd_data;
  assign oValid       = r_valid;
  assign oCount       = r_count;
  assign oFull        = w_full;
  assign oEmpty       = w_empty;
  assign oAlmostFull  = (r_count >= AF_TH);
  assign oAlmostEmpty = (r_count <= AE_TH);
  assign oOverflow    = r_overflow;
  assign oUnderflow   = r_underflow;

endmodule

// File: tb/tb_fifo_memory.sv
// Randomized and directed bench for fifo_memory against a queue-based model.
module tb_fifo_memory;

  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          Clock = 1'b0;
  logic          iReset_L;
  logic          iPush;
  logic          iPop;
  logic          iClearErr;
  logic [DW-1:0] iDataIn;
  logic [DW-1:0] oDataOut;
  logic          oValid;
  logic          oFull;
  logic          oEmpty;
  logic          oAlmostFull;
  logic          oAlmostEmpty;
  logic          oOverflow;
  logic          oUnderflow;
  logic [AW:0]   oCount;

  always #5 Clock = ~Clock;

  fifo_memory #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .Clock        (Clock),
    .iReset_L     (iReset_L),
    .iPush        (iPush),
    .iPop         (iPop),
    .iClearErr    (iClearErr),
    .iDataIn      (iDataIn),
    .oDataOut     (oDataOut),
    .oValid       (oValid),
    .oFull        (oFull),
    .oEmpty       (oEmpty),
    .oAlmostFull  (oAlmostFull),
    .oAlmostEmpty (oAlmostEmpty),
    .oOverflow    (oOverflow),
    .oUnderflow   (oUnderflow),
    .oCount       (oCount)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ovf;
  logic          m_ufl;
  int            checks = 0;
  int            errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_ufl   = 1'b0;
  endtask

  // One clock edge of FIFO behaviour expressed on a queue.
  task automatic model_edge(input bit p, input bit q, input bit c, input logic [DW-1:0] d);
    int  sz;
    bit  pop_ok;
    bit  push_ok;
    sz      = exp_q.size();
    pop_ok  = q && (sz > 0);
    push_ok = p && ((sz < DEPTH) || pop_ok);
    m_valid = pop_ok;
    if (pop_ok) m_data = exp_q.pop_front();
    if (push_ok) exp_q.push_back(d);
    m_ovf = (p && !push_ok) || (m_ovf && !c);
    m_ufl = (q && (sz == 0)) || (m_ufl && !c);
  endtask

  task automatic check_outputs(input string ctx);
    int sz;
    sz = exp_q.size();
    check_eq({ctx, ":count"}, 32'(oCount), 32'(sz));
    check_eq({ctx, ":full"},  32'(oFull),  32'(sz == DEPTH));
    check_eq({ctx, ":empty"}, 32'(oEmpty), 32'(sz == 0));
    check_eq({ctx, ":afull"}, 32'(oAlmostFull),  32'(sz >= DEPTH - 2));
    check_eq({ctx, ":aempty"}, 32'(oAlmostEmpty), 32'(sz <= 2));
    check_eq({ctx, ":ovf"},   32'(oOverflow),  32'(m_ovf));
    check_eq({ctx, ":ufl"},   32'(oUnderflow), 32'(m_ufl));
    check_eq({ctx, ":valid"}, 32'(oValid),     32'(m_valid));
    check_eq({ctx, ":data"},  32'(oDataOut),   32'(m_data));
  endtask

  // ---------------- driver tasks ----------------
  // Drive at the falling edge, model the rising edge, sample 1ns later.
  task automatic step(input string ctx, input bit p, input bit q, input bit c,
                      input logic [DW-1:0] d, input bit release_rst = 1'b0);
    @(negedge Clock);
    if (release_rst) iReset_L = 1'b1;
    iPush = p; iPop = q; iClearErr = c; iDataIn = d;
    @(posedge Clock);
    model_edge(p, q, c, d);
    #1;
    check_outputs(ctx);
  endtask

  task automatic idle_inputs();
    iPush = 1'b0; iPop = 1'b0; iClearErr = 1'b0; iDataIn = '0;
  endtask

  // Assert reset between clock edges and check outputs before any edge.
  task automatic async_reset(input string ctx);
    @(negedge Clock);
    idle_inputs();
    #2;
    iReset_L = 1'b0;
    model_reset();
    #1;
    check_outputs(ctx);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] w;
    iReset_L = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(posedge Clock);

    // Fill with 0x01..0x08; first push is on the first edge after release.
    for (int i = 1; i <= DEPTH; i++) begin
      w = DW'(i);
      step("fill", 1'b1, 1'b0, 1'b0, w, i == 1);
    end
    // Ninth push while full is rejected.
    step("ovf_push", 1'b1, 1'b0, 1'b0, 6'h3F);
    // Drain: each word appears one cycle after its pop.
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 1'b0, '0);
    step("drain_idle", 1'b0, 1'b0, 1'b0, '0);

    // Pop while empty, then clear the flags.
    step("ufl_pop", 1'b0, 1'b1, 1'b0, '0);
    step("clear", 1'b0, 1'b0, 1'b1, '0);
    // Clear and a new error on the same edge leave the flag set.
    step("clr_vs_err", 1'b0, 1'b1, 1'b1, '0);
    step("clear2", 1'b0, 1'b0, 1'b1, '0);

    // Refill, then push+pop while full across pointer wrap.
    for (int i = 0; i < DEPTH; i++) begin
      w = DW'($urandom_range(0, 63));
      step("refill", 1'b1, 1'b0, 1'b0, w);
    end
    for (int i = 0; i < 20; i++) step("full_pp", 1'b1, 1'b1, 1'b0, 6'h2A);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 1'b1, 1'b0, '0);
    step("clear3", 1'b0, 1'b0, 1'b1, '0);

    // Push+pop on empty: push taken, pop rejected.
    step("empty_pp", 1'b1, 1'b1, 1'b0, 6'h15);
    step("empty_pp_next", 1'b0, 1'b0, 1'b0, '0);
    step("pop_15", 1'b0, 1'b1, 1'b0, '0);

    // Mid-stream asynchronous reset with five words stored.
    for (int i = 0; i < 5; i++) begin
      w = DW'($urandom_range(0, 63));
      step("pre_rst", 1'b1, 1'b0, 1'b0, w);
    end
    async_reset("mid_rst");
    repeat (2) @(posedge Clock);
    step("post_rst_push", 1'b1, 1'b0, 1'b0, 6'h33, 1'b1);
    step("post_rst_pop", 1'b0, 1'b1, 1'b0, '0);

    // Randomized traffic with shifting push/pop bias.
    for (int i = 0; i < 600; i++) begin
      int bias;
      bit p;
      bit q;
      bit c;
      bias = (i / 100) % 3 == 0 ? 75 : ((i / 100) % 3 == 1 ? 25 : 50);
      p = ($urandom_range(0, 99) < bias);
      q = ($urandom_range(0, 99) < (100 - bias));
      c = ($urandom_range(0, 15) == 0);
      w = DW'($urandom_range(0, 63));
      step("rand", p, q, c, w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
